masku_operand_queue: RTL and testbench
======================================

# masku_operand_queue

Buffering stage directly upstream of the mask unit's operand-extraction logic. Accepts operands from every lane on independent per-lane, per-slot valid/ready channels and stores them in small FIFOs. Releases a lane-aligned operand bundle only when every slot the current instruction needs holds data in all lanes. The bundle leaves in the shuffled `[lane][slot]` layout the extraction stage consumes: slot 0 mask, slot 1 old destination, slots 2.. ALU/FPU results.

## Interface
- `NrLanes`, default 4: number of lanes.
- `Depth`, default 2: entries per (lane, slot) FIFO; must be ≥1; elaboration error otherwise.
- `NrSlots`, default `NrMaskFUnits+2`: operand slots per lane; derived, not overridden.
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: reset, synchronous, active-low.
- `flush_i` in, 1: synchronously discard all buffered operands.
- `slot_req_i` in, NrSlots: slots required by the current instruction; must be held stable while any FIFO is non-empty.
- `masku_operands_i` in, NrLanes×NrSlots×ELEN: incoming operands.
- `masku_operands_valid_i` in, NrLanes×NrSlots: per-channel valid.
- `masku_operands_ready_o` out, NrLanes×NrSlots: per-channel ready.
- `masku_operands_o` out, NrLanes×NrSlots×ELEN: aligned bundle, FIFO heads.
- `masku_operands_valid_o` out, 1: bundle valid.
- `masku_operands_ready_i` in, 1: downstream accepts bundle.
- `stall_cnt_o` out, 32: input-starvation counter; see Configuration.

## Operation
- Each (lane, slot) pair owns one FIFO with a count register of width `$clog2(Depth+1)`.
- `ready_o[l][s]` = `rst_ni && count[l][s] < Depth`.
  - Depends only on registered state; no combinational path from `masku_operands_ready_i`.
- Push: `valid_i && ready_o` writes at the tail.
- Pushes are accepted on every slot regardless of `slot_req_i`. Data in unrequired slots waits until a later instruction requires that slot, or until flush.
- `valid_o` = AND over all lanes and all slots with `slot_req_i[s]=1` of `count[l][s] != 0`.
  - If `slot_req_i` is all-zero, `valid_o` = 0.
- `masku_operands_o[l][s]` = head of FIFO when `slot_req_i[s]=1` and count != 0; otherwise all-zero.
- Pop: on `valid_o && ready_i`, every required FIFO in every lane pops exactly one entry. Unrequired FIFOs are untouched.
- Push and pop on the same FIFO in the same cycle: count unchanged, head advances, tail written.
  - Legal only when the FIFO was not full, since ready is computed pre-pop.
- Flush: all counts and pointers cleared next edge. Flush has priority over push and pop in the same cycle; the same-cycle push is dropped and no pop occurs. `valid_o` may be 1 in the flush cycle; a handshake in that cycle is ignored.
- Pointers wrap modulo `Depth`; non-power-of-two Depth is supported.

## Timing
- Reset (`rst_ni`=0 at edge): all counts and pointers 0, `stall_cnt_o` 0.
  - While `rst_ni`=0: `ready_o` all 0, `valid_o` 0, `masku_operands_o` 0.
  - Reset mid-operation discards all contents.
- Latency: an operand pushed at edge N is visible at `masku_operands_o` and can complete `valid_o` after edge N; no fall-through in the push cycle.
- Throughput: with Depth ≥2 and continuous input, one bundle per cycle. With Depth=1, one bundle every 2 cycles.
- `valid_o` and `masku_operands_o` are combinational from registered state only.

## Configuration
- `ARA_MASKU_OPQ_PERF_EN` defined:
  - `stall_cnt_o` increments, saturating at 2^32−1, each cycle with `ready_i`=1, `valid_o`=0, `slot_req_i`≠0, and at least one required FIFO non-empty.
  - Cleared by reset only, not by flush.
- Not defined: `stall_cnt_o` tied to 0; no counter register.

## Test plan
- Reset: hold `rst_ni`=0 for 3 cycles with all `valid_i`=1 → `ready_o`=0, `valid_o`=0. First cycle after release: `ready_o` all 1, counts 0.
- Alignment (NrLanes=4, `slot_req_i`=4'b0111): push lanes 0–2 at cycle 1, lane 3 at cycle 4 → `valid_o` rises cycle 5. Bundle slot 3 reads 0; slots 0–2 match pushed data per lane.
- Backpressure (Depth=2): `ready_i`=0, push 3 times on lane 0 slot 1 → third push stalls (`ready_o`=0 after 2). Raise `ready_i` → entries emerge in FIFO order.
- Streaming: continuous valid on required slots, `ready_i`=1, Depth=2 → one bundle per cycle for 16 cycles, no bubbles after the first.
- Flush: `flush_i` with 1 buffered bundle plus a same-cycle push and handshake → next cycle all counts 0, `valid_o`=0, pushed data absent.
- Perf (`ARA_MASKU_OPQ_PERF_EN`): lane 2 slot 0 withheld 5 cycles, others full, `ready_i`=1 → `stall_cnt_o`=5; with macro undefined → 0.

Source files
------------

// File: rtl/masku_operand_queue.sv
// masku_operand_queue
//
// Buffering stage in front of the mask unit's operand-extraction logic.
// Every (lane, slot) channel has its own small FIFO with an independent
// valid/ready handshake. A lane-aligned bundle is released only once every
// slot required by the current instruction holds data in all lanes. The
// bundle is presented in [lane][slot] order: slot 0 mask, slot 1 old
// destination, slots 2.. ALU/FPU results.
//
// Optional feature: define ARA_MASKU_OPQ_PERF_EN to enable the
// input-starvation counter on stall_cnt_o. When it is undefined,
// stall_cnt_o is tied to zero and no counter register exists.
//
// Parameters:
//   NrLanes      - number of lanes
//   Depth        - entries per (lane, slot) FIFO, at least 1
//   NrMaskFUnits - number of ALU/FPU result slots (NrSlots = NrMaskFUnits+2)
//   ELEN         - operand width in bits
//
// Ports:
//   clk_i                  - clock
//   rst_ni                 - synchronous active-low reset
//   flush_i                - discard all buffered operands at the next edge
//   slot_req_i             - slots required by the current instruction
//   masku_operands_i       - incoming operands [lane][slot]
//   masku_operands_valid_i - per-channel valid [lane][slot]
//   masku_operands_ready_o - per-channel ready [lane][slot]
//   masku_operands_o       - aligned bundle (FIFO heads, zero when unrequired)
//   masku_operands_valid_o - bundle valid
//   masku_operands_ready_i - downstream accepts the bundle
//   stall_cnt_o            - input-starvation cycle counter

module masku_operand_queue #(
    parameter int unsigned NrLanes      = 4,
    parameter int unsigned Depth        = 2,
    parameter int unsigned NrMaskFUnits = 2,
    parameter int unsigned ELEN         = 64,
    localparam int unsigned NrSlots     = NrMaskFUnits + 2
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       flush_i,
    input  logic [NrSlots-1:0]                         slot_req_i,
    input  logic [NrLanes-1:0][NrSlots-1:0][ELEN-1:0]  masku_operands_i,
    input  logic [NrLanes-1:0][NrSlots-1:0]            masku_operands_valid_i,
    output logic [NrLanes-1:0][NrSlots-1:0]            masku_operands_ready_o,
    output logic [NrLanes-1:0][NrSlots-1:0][ELEN-1:0]  masku_operands_o,
    output logic                                       masku_operands_valid_o,
    input  logic                                       masku_operands_ready_i,
    output logic [31:0]                                stall_cnt_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

    if (Depth < 1) begin : gen_depth_check
        $error("masku_operand_queue: Depth must be at least 1");
    end

    logic [NrLanes-1:0][NrSlots-1:0] nonempty;
    logic                            bundle_valid;
    logic                            pop_all;

    // A bundle exists only if some slot is required and every required
    // FIFO in every lane has at least one entry.
    always_comb begin
        bundle_valid = |slot_req_i;
        for (int l = 0; l < int'(NrLanes); l++) begin
            for (int s = 0; s < int'(NrSlots); s++) begin
                if (slot_req_i[s] && !nonempty[l][s]) begin
                    bundle_valid = 1'b0;
                end
            end
        end
    end

    assign masku_operands_valid_o = rst_ni && bundle_valid;
    assign pop_all                = masku_operands_valid_o && masku_operands_ready_i;

    genvar gi, gs;
    for (gi = 0; gi < int'(NrLanes); gi++) begin : gen_lane
        for (gs = 0; gs < int'(NrSlots); gs++) begin : gen_slot
            logic [ELEN-1:0] mem [Depth];
            logic [PtrW-1:0] rd_ptr_reg;
            logic [PtrW-1:0] wr_ptr_reg;
            logic [CntW-1:0] count_reg;
            logic            push;
            logic            pop;

            // Ready looks only at the pre-pop count, so a full FIFO cannot
            // accept a push even when it is popped in the same cycle.
            assign masku_operands_ready_o[gi][gs] = rst_ni && (count_reg < DepthCnt);
            assign nonempty[gi][gs] = (count_reg != '0);

            // Flush wins over any same-cycle push or pop.
            assign push = masku_operands_valid_i[gi][gs] && masku_operands_ready_o[gi][gs]
                          && !flush_i;
            assign pop  = pop_all && slot_req_i[gs] && !flush_i;

            always_ff @(posedge clk_i) begin
                if (!rst_ni || flush_i) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= (wr_ptr_reg == LastPtr) ? '0 : wr_ptr_reg + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr_reg <= (rd_ptr_reg == LastPtr) ? '0 : rd_ptr_reg + 1'b1;
                    end
                    case ({push, pop})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            // Storage carries no reset; validity is tracked by count_reg.
            always_ff @(posedge clk_i) begin
                if (push) begin
                    mem[wr_ptr_reg] <= masku_operands_i[gi][gs];
                end
            end

            assign masku_operands_o[gi][gs] =
                (rst_ni && slot_req_i[gs] && nonempty[gi][gs]) ? mem[rd_ptr_reg] : '0;
        end
    end

`ifdef ARA_MASKU_OPQ_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic        any_pending;

    // Starvation: downstream is ready and some required data has arrived,
    // but at least one required channel is still empty.
    always_comb begin
        any_pending = 1'b0;
        for (int l = 0; l < int'(NrLanes); l++) begin
            for (int s = 0; s < int'(NrSlots); s++) begin
                if (slot_req_i[s] && nonempty[l][s]) begin
                    any_pending = 1'b1;
                end
            end
        end
    end

    // Cleared by reset only; flush leaves the statistic intact.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_reg <= '0;
        end else if (masku_operands_ready_i && !masku_operands_valid_o && (|slot_req_i)
                     && any_pending && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_masku_operand_queue.sv
// Directed testbench for masku_operand_queue (NrLanes=4, Depth=2, NrSlots=4).
// Inputs are driven shortly after the rising edge and outputs are checked
// one time unit later, well away from the next active edge.

module tb_masku_operand_queue;

    localparam int NL = 4;
    localparam int NS = 4;
    localparam int EL = 64;

`ifdef ARA_MASKU_OPQ_PERF_EN
    localparam logic [31:0] PerfExp = 32'd5;
`else
    localparam logic [31:0] PerfExp = 32'd0;
`endif

    logic                          clk;
    logic                          rst_n;
    logic                          flush;
    logic [NS-1:0]                 slot_req;
    logic [NL-1:0][NS-1:0][EL-1:0] ops_in;
    logic [NL-1:0][NS-1:0]         vld_in;
    logic [NL-1:0][NS-1:0]         rdy_out;
    logic [NL-1:0][NS-1:0][EL-1:0] ops_out;
    logic                          vld_out;
    logic                          rdy_in;
    logic [31:0]                   stall_cnt;

    int vectors;
    int miscompares;

    masku_operand_queue #(
        .NrLanes      (NL),
        .Depth        (2),
        .NrMaskFUnits (2),
        .ELEN         (EL)
    ) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .flush_i                (flush),
        .slot_req_i             (slot_req),
        .masku_operands_i       (ops_in),
        .masku_operands_valid_i (vld_in),
        .masku_operands_ready_o (rdy_out),
        .masku_operands_o       (ops_out),
        .masku_operands_valid_o (vld_out),
        .masku_operands_ready_i (rdy_in),
        .stall_cnt_o            (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dat(input int l, input int s, input int k);
        return 64'hC0DE_0000_0000_0000 | 64'(l << 12) | 64'(s << 8) | 64'(k & 255);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("pass %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input int k, input logic [3:0] lmask, input logic [3:0] smask);
        for (int l = 0; l < NL; l++) begin
            for (int s = 0; s < NS; s++) begin
                if (lmask[l] && smask[s]) begin
                    vld_in[l][s] = 1'b1;
                    ops_in[l][s] = dat(l, s, k);
                end
            end
        end
    endtask

    task automatic clear_valid();
        vld_in = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        slot_req    = 4'b0111;
        ops_in      = '0;
        vld_in      = '1;
        rdy_in      = 1'b0;

        // Reset held 3 cycles with every valid asserted.
        repeat (3) tick();
        check("rst_ready", 64'(rdy_out), 64'h0);
        check("rst_valid", 64'(vld_out), 64'h0);
        for (int l = 0; l < NL; l++) begin
            check($sformatf("rst_ops_l%0d", l), ops_out[l][0] | ops_out[l][1] | ops_out[l][2], 64'h0);
        end
        rst_n = 1'b1;
        clear_valid();
        settle();
        check("post_rst_ready", 64'(rdy_out), 64'hFFFF);
        check("post_rst_valid", 64'(vld_out), 64'h0);
        check("post_rst_stall", 64'(stall_cnt), 64'h0);

        // Alignment: lanes 0-2 first, lane 3 three cycles later.
        drive(1, 4'b0111, 4'b0111);
        tick();
        clear_valid();
        settle();
        check("align_partial_valid", 64'(vld_out), 64'h0);
        tick();
        tick();
        check("align_still_waiting", 64'(vld_out), 64'h0);
        drive(1, 4'b1000, 4'b0111);
        tick();
        clear_valid();
        settle();
        check("align_valid", 64'(vld_out), 64'h1);
        for (int l = 0; l < NL; l++) begin
            for (int s = 0; s < NS; s++) begin
                check($sformatf("align_l%0d_s%0d", l, s), ops_out[l][s],
                      (s < 3) ? dat(l, s, 1) : 64'h0);
            end
        end
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        settle();
        check("align_popped_valid", 64'(vld_out), 64'h0);

        // Backpressure on slot 1 with Depth=2.
        slot_req = 4'b0010;
        drive(0, 4'b1111, 4'b0010);
        tick();
        check("bp_ready_after1", 64'(rdy_out[0][1]), 64'h1);
        drive(1, 4'b1111, 4'b0010);
        tick();
        check("bp_ready_after2", 64'(rdy_out[0][1]), 64'h0);
        drive(2, 4'b1111, 4'b0010);
        tick();
        check("bp_ready_stalled", 64'(rdy_out[0][1]), 64'h0);
        check("bp_valid", 64'(vld_out), 64'h1);
        check("bp_head0_l0", ops_out[0][1], dat(0, 1, 0));
        clear_valid();
        rdy_in = 1'b1;
        tick();
        check("bp_head1_l0", ops_out[0][1], dat(0, 1, 1));
        check("bp_head1_l3", ops_out[3][1], dat(3, 1, 1));
        check("bp_valid2", 64'(vld_out), 64'h1);
        tick();
        rdy_in = 1'b0;
        settle();
        check("bp_drained_valid", 64'(vld_out), 64'h0);
        check("bp_drained_ready", 64'(rdy_out[0][1]), 64'h1);

        // Streaming: one bundle per cycle for 16 cycles.
        slot_req = 4'b0111;
        rdy_in   = 1'b1;
        drive(0, 4'b1111, 4'b0111);
        tick();
        for (int n = 0; n < 16; n++) begin
            check($sformatf("stream_valid_%0d", n), 64'(vld_out), 64'h1);
            check($sformatf("stream_data_%0d", n), ops_out[n % 4][n % 3], dat(n % 4, n % 3, n));
            drive(n + 1, 4'b1111, 4'b0111);
            tick();
        end
        clear_valid();
        tick();
        rdy_in = 1'b0;
        settle();
        check("stream_drained_valid", 64'(vld_out), 64'h0);

        // Flush with a buffered bundle, same-cycle push and handshake.
        drive(8'h40, 4'b1111, 4'b0111);
        tick();
        clear_valid();
        settle();
        check("flush_pre_valid", 64'(vld_out), 64'h1);
        drive(8'h41, 4'b1111, 4'b0111);
        flush  = 1'b1;
        rdy_in = 1'b1;
        tick();
        flush  = 1'b0;
        rdy_in = 1'b0;
        clear_valid();
        settle();
        check("flush_valid", 64'(vld_out), 64'h0);
        check("flush_ready", 64'(rdy_out), 64'hFFFF);
        drive(8'h42, 4'b1111, 4'b0111);
        tick();
        clear_valid();
        settle();
        check("flush_after_valid", 64'(vld_out), 64'h1);
        check("flush_after_head", ops_out[1][2], dat(1, 2, 8'h42));
        check("flush_stall", 64'(stall_cnt), 64'h0);
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        settle();

        // Starvation: lane 2 slot 0 withheld for 5 edges.
        slot_req = 4'b0001;
        rdy_in   = 1'b1;
        drive(5, 4'b1011, 4'b0001);
        tick();
        clear_valid();
        repeat (4) tick();
        drive(5, 4'b0100, 4'b0001);
        tick();
        clear_valid();
        settle();
        check("perf_valid", 64'(vld_out), 64'h1);
        check("perf_stall", 64'(stall_cnt), 64'(PerfExp));
        tick();
        rdy_in = 1'b0;
        settle();
        check("perf_popped_valid", 64'(vld_out), 64'h0);
        check("perf_stall_hold", 64'(stall_cnt), 64'(PerfExp));

        // Data in an unrequired slot, then a mid-operation reset.
        drive(7, 4'b1111, 4'b1000);
        tick();
        clear_valid();
        settle();
        check("unreq_valid", 64'(vld_out), 64'h0);
        check("unreq_zero_out", ops_out[0][3], 64'h0);
        rst_n = 1'b0;
        settle();
        check("midrst_ready", 64'(rdy_out), 64'h0);
        tick();
        rst_n = 1'b1;
        settle();
        check("midrst_stall", 64'(stall_cnt), 64'h0);
        check("midrst_ready_after", 64'(rdy_out), 64'hFFFF);
        slot_req = 4'b1000;
        settle();
        check("midrst_discarded", 64'(vld_out), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
